muldiv_sched: RTL and testbench

MULDIV_SCHED -- requirements
Module: muldiv_sched

---
 rtl/muldiv_sched.sv | 174 +++++++++++++++++
 tb/tb_muldiv_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_sched: two-slot MULT/DIV issue scheduler with sign handling for an |
// | external unsigned engine. Optional MULDIV_DIV0_FAST_EN: divide-by-zero    |
// | bypasses the engine and writes hi=a, lo=all-ones.                         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module muldiv_sched (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    input  logic [1:0][1:0]  req_op,
    input  logic [1:0][31:0] req_a,
    input  logic [1:0][31:0] req_b,
    input  logic             flush,
    output logic             stall,
    output logic             eng_start,
    output logic             eng_abort,
    output logic             eng_is_div,
    output logic [31:0]      eng_a,
    output logic [31:0]      eng_b,
    input  logic             eng_done,
    input  logic [63:0]      eng_res,
    output logic             hilo_we,
    output logic [63:0]      hilo_data,
    output logic             hilo_slot,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  served_q, served_d;
    logic        is_div_q, is_div_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        slot_q, slot_d;
    logic [63:0] res_q, res_d;

    logic [1:0]  pending;
    logic [1:0]  slot_bit;
    logic        sel_slot;
    logic [1:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        sel_sa;
    logic        sel_sb;
    logic        write_done;
    logic        stall_raw;
    logic        neg;
    logic [63:0] mul_res;
    logic [31:0] div_lo;
    logic [31:0] div_hi;

    always_comb begin
        state_d  = state_q;
        served_d = served_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        a_d      = a_q;
        b_d      = b_q;
        slot_d   = slot_q;
        res_d    = res_q;

        // Slot 1 is the older instruction, so it wins the arbitration.
        pending  = req_valid & ~served_q;
        sel_slot = pending[1];
        sel_op   = req_op[sel_slot];
        sel_a    = req_a[sel_slot];
        sel_b    = req_b[sel_slot];
        sel_sa   = ~sel_op[0] & sel_a[31];
        sel_sb   = ~sel_op[0] & sel_b[31];

        neg      = sa_q ^ sb_q;
        mul_res  = neg ? -eng_res : eng_res;
        div_lo   = neg ? -eng_res[31:0] : eng_res[31:0];
        div_hi   = sa_q ? -eng_res[63:32] : eng_res[63:32];

        slot_bit   = slot_q ? 2'b10 : 2'b01;
        write_done = (state_q == S_WB) && !flush;
        // The write of the last outstanding slot releases the pipeline in the same cycle.
        if (write_done) begin
            stall_raw = (req_valid & ~(served_q | slot_bit)) != 2'b00;
        end else begin
            stall_raw = (pending != 2'b00) || (state_q != S_IDLE);
        end

        case (state_q)
            S_IDLE: begin
                if (pending != 2'b00) begin
                    slot_d   = sel_slot;
                    is_div_d = sel_op[1];
                    sa_d     = sel_sa;
                    sb_d     = sel_sb;
                    a_d      = sel_sa ? -sel_a : sel_a;
                    b_d      = sel_sb ? -sel_b : sel_b;
                    state_d  = S_START;
`ifdef MULDIV_DIV0_FAST_EN
                    if (sel_op[1] && (sel_b == 32'd0)) begin
                        res_d   = {sel_a, 32'hFFFF_FFFF};
                        state_d = S_WB;
                    end
`endif
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (eng_done) begin
                    res_d   = is_div_q ? {div_hi, div_lo} : mul_res;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                served_d = served_q | slot_bit;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!stall_raw) begin
            served_d = 2'b00;
        end
        if (flush) begin
            state_d  = S_IDLE;
            served_d = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            served_q <= 2'b00;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            slot_q   <= 1'b0;
            res_q    <= 64'd0;
        end else begin
            state_q  <= state_d;
            served_q <= served_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            a_q      <= a_d;
            b_q      <= b_d;
            slot_q   <= slot_d;
            res_q    <= res_d;
        end
    end

    // stall reads req_valid directly, so it must be masked while reset is held.
    assign stall      = ~reset & stall_raw;
    assign eng_start  = (state_q == S_START);
    assign eng_abort  = flush && ((state_q == S_START) || (state_q == S_WAIT));
    assign eng_is_div = is_div_q;
    assign eng_a      = a_q;
    assign eng_b      = b_q;
    assign hilo_we    = write_done;
    assign hilo_data  = res_q;
    assign hilo_slot  = slot_q;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_muldiv_sched: scoreboard bench for muldiv_sched with a simple engine.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_muldiv_sched;

    logic             clk;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0][1:0]  req_op;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic             flush;
    logic             stall;
    logic             eng_start;
    logic             eng_abort;
    logic             eng_is_div;
    logic [31:0]      eng_a;
    logic [31:0]      eng_b;
    logic             eng_done;
    logic [63:0]      eng_res;
    logic             hilo_we;
    logic [63:0]      hilo_data;
    logic             hilo_slot;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    int eng_lat  = 1;

    logic [64:0] exp_hilo[$];
    logic [64:0] exp_eng[$];
    logic [63:0] eng_res_q[$];

    muldiv_sched dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .flush(flush), .stall(stall),
        .eng_start(eng_start), .eng_abort(eng_abort), .eng_is_div(eng_is_div),
        .eng_a(eng_a), .eng_b(eng_b), .eng_done(eng_done), .eng_res(eng_res),
        .hilo_we(hilo_we), .hilo_data(hilo_data), .hilo_slot(hilo_slot), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Engine: after eng_start, returns the next queued raw result eng_lat cycles into WAIT.
    initial begin
        logic [63:0] r;
        int          lat;
        eng_done = 1'b0;
        eng_res  = 64'd0;
        forever begin
            @(negedge clk);
            if (eng_start && !reset) begin
                lat = eng_lat;
                r   = (eng_res_q.size() != 0) ? eng_res_q.pop_front() : 64'd0;
                repeat (lat) @(posedge clk);
                #1;
                eng_done = 1'b1;
                eng_res  = r;
                @(posedge clk);
                #1;
                eng_done = 1'b0;
            end
        end
    end

    // Monitor: compares engine launches and HI/LO writes against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (eng_start) begin
                if (exp_eng.size() == 0) check("eng_start_unexpected", 1'b1, 1'b0);
                else check("eng_operands", {eng_is_div, eng_a, eng_b}, exp_eng.pop_front());
            end
            if (hilo_we) begin
                if (exp_hilo.size() == 0) check("hilo_we_unexpected", 1'b1, 1'b0);
                else check("hilo_write", {hilo_slot, hilo_data}, exp_hilo.pop_front());
            end
        end
    end

    // Holds the request until stall drops, checking stall timing and latency.
    task automatic issue(input logic [1:0] v,
                         input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic [1:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input int exp_lat);
        int cycles;
        req_valid = v;
        req_op    = {op1, op0};
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        cycles    = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) check("stall_on_request", stall, 1'b1);
        end while (stall && cycles < 60);
        if (stall) begin
            check("stall_timeout", 1'b1, 1'b0);
        end else begin
            check("stall_drop_in_wb", hilo_we, 1'b1);
            if (exp_lat != 0) check("latency", 65'(cycles), 65'(exp_lat));
        end
        tick();
        req_valid = 2'b00;
        tick();
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!eng_start && n < 20);
        if (!eng_start) check("eng_start_timeout", 1'b1, 1'b0);
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 2'b11;
        req_op    = '0;
        req_a     = {32'd5, 32'd5};
        req_b     = {32'd5, 32'd5};
        flush     = 1'b0;
        #12;
        check("reset_stall", stall, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_outputs", {eng_start, eng_abort, eng_is_div, hilo_we, hilo_slot}, 5'd0);
        check("reset_data", {hilo_data, eng_a | eng_b}, 96'd0);
        req_valid = 2'b00;
        tick();
        reset = 1'b0;
        tick();
        tick();

        // Signed multiply, negative operand, 4-cycle engine.
        eng_lat = 4;
        eng_res_q.push_back(64'd6);
        exp_eng.push_back({1'b0, 32'd2, 32'd3});
        exp_hilo.push_back({1'b1, 64'hFFFF_FFFF_FFFF_FFFA});
        issue(2'b10, 2'b00, 32'hFFFF_FFFE, 32'd3, 2'b00, 32'd0, 32'd0, 7);

        // Signed divide -7/2.
        eng_lat = 2;
        eng_res_q.push_back({32'd1, 32'd3});
        exp_eng.push_back({1'b1, 32'd7, 32'd2});
        exp_hilo.push_back({1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
        issue(2'b01, 2'b00, 32'd0, 32'd0, 2'b10, 32'hFFFF_FFF9, 32'd2, 5);

        // Unsigned divide 7/2.
        eng_lat = 1;
        eng_res_q.push_back({32'd1, 32'd3});
        exp_eng.push_back({1'b1, 32'd7, 32'd2});
        exp_hilo.push_back({1'b0, 64'h0000_0001_0000_0003});
        issue(2'b01, 2'b00, 32'd0, 32'd0, 2'b11, 32'd7, 32'd2, 4);

        // Both slots: slot 1 first, stall held until slot 0 writes.
        eng_lat = 1;
        eng_res_q.push_back(64'd25);
        eng_res_q.push_back(64'd4);
        exp_eng.push_back({1'b0, 32'd5, 32'd5});
        exp_eng.push_back({1'b0, 32'd2, 32'd2});
        exp_hilo.push_back({1'b1, 64'd25});
        exp_hilo.push_back({1'b0, 64'd4});
        issue(2'b11, 2'b01, 32'd5, 32'd5, 2'b01, 32'd2, 32'd2, 8);

        // Most-negative operand magnitude passes through: (-2^31) * (-1) = 2^31.
        eng_lat = 3;
        eng_res_q.push_back(64'h0000_0000_8000_0000);
        exp_eng.push_back({1'b0, 32'h8000_0000, 32'd1});
        exp_hilo.push_back({1'b1, 64'h0000_0000_8000_0000});
        issue(2'b10, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'd0, 32'd0, 6);

        // Divide by zero.
        eng_lat = 1;
        exp_hilo.push_back({1'b0, 32'd9, 32'hFFFF_FFFF});
`ifdef MULDIV_DIV0_FAST_EN
        issue(2'b01, 2'b00, 32'd0, 32'd0, 2'b10, 32'd9, 32'd0, 2);
`else
        eng_res_q.push_back({32'd9, 32'hFFFF_FFFF});
        exp_eng.push_back({1'b1, 32'd9, 32'd0});
        issue(2'b01, 2'b00, 32'd0, 32'd0, 2'b10, 32'd9, 32'd0, 4);
`endif

        // Flush in WAIT: abort pulse, no write, late eng_done ignored.
        eng_lat = 6;
        eng_res_q.push_back(64'd1);
        exp_eng.push_back({1'b0, 32'd1, 32'd1});
        req_valid = 2'b10;
        req_op    = {2'b01, 2'b00};
        req_a     = {32'd1, 32'd0};
        req_b     = {32'd1, 32'd0};
        wait_start();
        flush = 1'b1;
        @(negedge clk);
        check("flush_abort", eng_abort, 1'b1);
        check("flush_no_write", hilo_we, 1'b0);
        tick();
        flush     = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        check("flush_idle", busy, 1'b0);
        check("flush_abort_single", eng_abort, 1'b0);
        repeat (10) tick();
        check("late_done_ignored", {busy, stall}, 2'b00);

        // Reset in WAIT: outputs clear at once, nothing written afterwards.
        eng_lat = 6;
        eng_res_q.push_back(64'd9);
        exp_eng.push_back({1'b0, 32'd3, 32'd3});
        req_valid = 2'b01;
        req_op    = {2'b00, 2'b01};
        req_a     = {32'd0, 32'd3};
        req_b     = {32'd0, 32'd3};
        wait_start();
        #1;
        reset = 1'b1;
        #1;
        check("midreset_busy_stall", {busy, stall}, 2'b00);
        check("midreset_eng", {eng_start, eng_is_div, eng_a, eng_b}, 66'd0);
        req_valid = 2'b00;
        tick();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_reset_idle", {busy, stall, hilo_we}, 3'd0);
        repeat (10) tick();

        check("hilo_queue_drained", 65'(exp_hilo.size()), 65'd0);
        check("eng_queue_drained", 65'(exp_eng.size()), 65'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
